// File: rtl/io_input_ctrl.sv
// io_input_ctrl: switch/key page responder with sync, debounce, sticky rising-edge capture and masked irq
module io_input_ctrl #(
    parameter int NUM_IN          = 32,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [NUM_IN-1:0] i_sw_raw,
    input  logic [31:0]       i_lsu_addr,
    input  logic              i_lsu_wren,
    input  logic [31:0]       i_st_data,
    output logic [31:0]       o_rd_data,
    output logic              o_irq
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_IN-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NUM_IN-1:0] h1_q, h1_d, h2_q, h2_d, stable_q, stable_d;
    logic [NUM_IN-1:0] edges_q, edges_d, mask_q, mask_d;
    logic [NUM_IN-1:0] agree, clr, sel;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              irq_q, irq_d, tick, hit, wr;
    logic [1:0]        off;
    logic              unused_ok;

    always_comb begin
        hit       = i_lsu_addr[31:12] == 20'h10010;
        off       = i_lsu_addr[3:2];
        wr        = i_lsu_wren && hit;
        tick      = cnt_q == CNT_MAX;
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        sync1_d   = i_sw_raw;
        sync2_d   = sync1_q;
        h1_d      = tick ? sync2_q : h1_q;
        h2_d      = tick ? h1_q : h2_q;
        // a bit only moves when the current sample and both history samples agree
        agree     = ~(sync2_q ^ h1_q) & ~(h1_q ^ h2_q);
        stable_d  = tick ? (agree & sync2_q) | (~agree & stable_q) : stable_q;
        clr       = (wr && off == 2'd1) ? i_st_data[NUM_IN-1:0] : '0;
        edges_d   = (edges_q & ~clr) | (stable_d & ~stable_q);
        mask_d    = (wr && off == 2'd2) ? i_st_data[NUM_IN-1:0] : mask_q;
        irq_d     = |(edges_q & mask_q);
        sel       = off == 2'd0 ? stable_q : off == 2'd1 ? edges_q : off == 2'd2 ? mask_q : sync2_q;
        o_rd_data = hit ? 32'(sel) : '0;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            h1_q     <= '0;
            h2_q     <= '0;
            stable_q <= '0;
            edges_q  <= '0;
            mask_q   <= '0;
            cnt_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            h1_q     <= h1_d;
            h2_q     <= h2_d;
            stable_q <= stable_d;
            edges_q  <= edges_d;
            mask_q   <= mask_d;
            cnt_q    <= cnt_d;
            irq_q    <= irq_d;
        end
    end

    assign o_irq     = irq_q;
    assign unused_ok = ^{i_lsu_addr[11:4], i_lsu_addr[1:0], i_st_data};
endmodule

// File: tb/tb_io_input_ctrl.sv
// tb_io_input_ctrl: directed checks of io_input_ctrl with NUM_IN=8, DEBOUNCE_CYCLES=4
module tb_io_input_ctrl;
    localparam logic [31:0] A_STAT = 32'h1001_0000;
    localparam logic [31:0] A_EDGE = 32'h1001_0004;
    localparam logic [31:0] A_MASK = 32'h1001_0008;
    localparam logic [31:0] A_RAW  = 32'h1001_000C;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic [7:0]  i_sw_raw = '0;
    logic [31:0] i_lsu_addr = '0;
    logic        i_lsu_wren = 1'b0;
    logic [31:0] i_st_data = '0;
    logic [31:0] o_rd_data;
    logic        o_irq;
    int          vecs = 0;
    int          errs = 0;

    io_input_ctrl #(.NUM_IN(8), .DEBOUNCE_CYCLES(4)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_sw_raw(i_sw_raw),
        .i_lsu_addr(i_lsu_addr), .i_lsu_wren(i_lsu_wren), .i_st_data(i_st_data),
        .o_rd_data(o_rd_data), .o_irq(o_irq)
    );

    always #5 i_clk = ~i_clk;

    task automatic step(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        i_lsu_addr = a;
        #1;
        d = o_rd_data;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        i_lsu_addr = a;
        i_st_data  = d;
        i_lsu_wren = 1'b1;
        step(1);
        i_lsu_wren = 1'b0;
    endtask

    task automatic do_reset(input logic [7:0] sw);
        i_sw_raw  = sw;
        i_reset_n = 1'b0;
        step(2);
        i_reset_n = 1'b1;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic [31:0] addrs[3] = '{A_STAT, A_EDGE, A_MASK};
        i_sw_raw = 8'hFF;
        step(20);
        wr(A_MASK, 32'hFF);
        step(2);
        i_reset_n = 1'b0;
        #1;
        vecs++;
        if (o_irq !== 1'b0) begin errs++; $display("FAIL reset_async_irq: got %b want 0", o_irq); end
        foreach (addrs[i]) begin
            rd(addrs[i], d);
            vecs++;
            if (d !== 32'h0) begin errs++; $display("FAIL reset_async_rd %h: got %h want 0", addrs[i], d); end
        end
        step(2);
        i_reset_n = 1'b1;
        foreach (addrs[i]) begin
            rd(addrs[i], d);
            vecs++;
            if (d !== 32'h0) begin errs++; $display("FAIL reset_release_rd %h: got %h want 0", addrs[i], d); end
        end
        vecs++;
        if (o_irq !== 1'b0) begin errs++; $display("FAIL reset_release_irq: got %b want 0", o_irq); end
        step(1);
        rd(A_RAW, d);
        vecs++;
        if (d !== 32'h0) begin errs++; $display("FAIL reset_raw_1clk: got %h want 0", d); end
        step(1);
        rd(A_RAW, d);
        vecs++;
        if (d !== 32'hFF) begin errs++; $display("FAIL reset_raw_2clk: got %h want ff", d); end
    endtask

    task automatic test_debounce;
        logic [31:0] d;
        do_reset(8'h05);
        step(1);
        rd(A_RAW, d);
        vecs++;
        if (d !== 32'h0) begin errs++; $display("FAIL deb_raw_1clk: got %h want 0", d); end
        step(1);
        rd(A_RAW, d);
        vecs++;
        if (d !== 32'h05) begin errs++; $display("FAIL deb_raw_2clk: got %h want 05", d); end
        step(9);
        rd(A_STAT, d);
        vecs++;
        if (d !== 32'h0) begin errs++; $display("FAIL deb_status_early: got %h want 0", d); end
        rd(A_EDGE, d);
        vecs++;
        if (d !== 32'h0) begin errs++; $display("FAIL deb_edge_early: got %h want 0", d); end
        step(1);
        rd(A_STAT, d);
        vecs++;
        if (d !== 32'h05) begin errs++; $display("FAIL deb_status_accept: got %h want 05", d); end
        rd(A_EDGE, d);
        vecs++;
        if (d !== 32'h05) begin errs++; $display("FAIL deb_edge_accept: got %h want 05", d); end
    endtask

    task automatic test_glitch;
        logic [31:0] d;
        i_sw_raw = 8'h0D;
        for (int i = 1; i <= 20; i++) begin
            step(1);
            if (i == 5) i_sw_raw = 8'h05;
            rd(A_STAT, d);
            vecs++;
            if (d !== 32'h05) begin errs++; $display("FAIL glitch_status cyc %0d: got %h want 05", i, d); end
            rd(A_EDGE, d);
            vecs++;
            if (d !== 32'h05) begin errs++; $display("FAIL glitch_edge cyc %0d: got %h want 05", i, d); end
        end
    endtask

    task automatic test_w1c_irq;
        logic [31:0] d;
        wr(A_MASK, 32'h04);
        vecs++;
        if (o_irq !== 1'b0) begin errs++; $display("FAIL irq_same_clk: got %b want 0", o_irq); end
        rd(A_MASK, d);
        vecs++;
        if (d !== 32'h04) begin errs++; $display("FAIL mask_readback: got %h want 04", d); end
        step(1);
        vecs++;
        if (o_irq !== 1'b1) begin errs++; $display("FAIL irq_assert: got %b want 1", o_irq); end
        wr(A_EDGE, 32'h04);
        rd(A_EDGE, d);
        vecs++;
        if (d !== 32'h01) begin errs++; $display("FAIL w1c_edge: got %h want 01", d); end
        vecs++;
        if (o_irq !== 1'b1) begin errs++; $display("FAIL irq_hold_w1c_clk: got %b want 1", o_irq); end
        step(1);
        vecs++;
        if (o_irq !== 1'b0) begin errs++; $display("FAIL irq_deassert: got %b want 0", o_irq); end
    endtask

    task automatic test_collision;
        logic [31:0] d;
        do_reset(8'h07);
        step(11);
        rd(A_STAT, d);
        vecs++;
        if (d !== 32'h0) begin errs++; $display("FAIL coll_status_pre: got %h want 0", d); end
        wr(A_EDGE, 32'h02);
        rd(A_STAT, d);
        vecs++;
        if (d !== 32'h07) begin errs++; $display("FAIL coll_status_rise: got %h want 07", d); end
        rd(A_EDGE, d);
        vecs++;
        if (d !== 32'h07) begin errs++; $display("FAIL coll_set_wins: got %h want 07", d); end
        wr(A_EDGE, 32'h02);
        rd(A_EDGE, d);
        vecs++;
        if (d !== 32'h05) begin errs++; $display("FAIL coll_later_clear: got %h want 05", d); end
    endtask

    task automatic test_decode;
        logic [31:0] d;
        rd(32'h1000_0000, d);
        vecs++;
        if (d !== 32'h0) begin errs++; $display("FAIL dec_miss: got %h want 0", d); end
        wr(A_STAT, 32'hFFFF_FFFF);
        rd(A_STAT, d);
        vecs++;
        if (d !== 32'h07) begin errs++; $display("FAIL dec_status_ro: got %h want 07", d); end
        rd(A_EDGE, d);
        vecs++;
        if (d !== 32'h05) begin errs++; $display("FAIL dec_edge_untouched: got %h want 05", d); end
        rd(A_MASK, d);
        vecs++;
        if (d !== 32'h0) begin errs++; $display("FAIL dec_mask_untouched: got %h want 0", d); end
        wr(A_RAW, 32'hFFFF_FFFF);
        rd(32'h1001_000F, d);
        vecs++;
        if (d !== 32'h07) begin errs++; $display("FAIL dec_raw_ro: got %h want 07", d); end
        wr(A_MASK, 32'h5A);
        rd(32'h1001_0018, d);
        vecs++;
        if (d !== 32'h5A) begin errs++; $display("FAIL dec_alias_mask: got %h want 5a", d); end
        step(1);
        vecs++;
        if (o_irq !== 1'b0) begin errs++; $display("FAIL dec_irq_masked: got %b want 0", o_irq); end
        wr(32'h1001_0FF8, 32'hFFFF_FFFF);
        rd(A_MASK, d);
        vecs++;
        if (d !== 32'hFF) begin errs++; $display("FAIL dec_mask_zext: got %h want ff", d); end
        step(1);
        vecs++;
        if (o_irq !== 1'b1) begin errs++; $display("FAIL dec_irq_enabled: got %b want 1", o_irq); end
    endtask

    initial begin
        step(2);
        i_reset_n = 1'b1;
        step(3);
        test_reset;
        test_debounce;
        test_glitch;
        test_w1c_irq;
        test_collision;
        test_decode;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
